vga_pixel_pipe: RTL

- Pixel source stage sitting directly upstream of the VGA output pins. It consumes per-pixel coordinates and syncs from the 640x480@60 timing generator.
- Holds a double-buffered 160x120 framebuffer of 4-bit palette indices, upscaled 4x in each axis. Indices map through a 16-entry 12-bit palette.
- Drives RGB, hsync and vsync with a fixed, aligned 2-cycle latency. Writers fill the back buffer through a valid/ready port; a swap request exchanges the buffers at the next vsync start.

---
 rtl/vga_pixel_pipe.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/vga_pixel_pipe.sv
// Pixel source stage: double-buffered 160x120 indexed framebuffer, 4x upscale,
// 16-entry palette, RGB and syncs presented with an aligned 2-cycle latency.
module vga_pixel_pipe #(
    parameter int VGA_COLOR_DEPTH = 4,
    parameter int FB_WIDTH        = 160,
    parameter int FB_HEIGHT       = 120,
    parameter int SCALE_SHIFT     = 2,
    parameter int PIXEL_BITS      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [9:0]                   pixel_x,
    input  logic [9:0]                   pixel_y,
    input  logic                         visible_in,
    input  logic                         hsync_in,
    input  logic                         vsync_in,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [14:0]                  wr_addr,
    input  logic [PIXEL_BITS-1:0]        wr_data,
    input  logic                         pal_we,
    input  logic [PIXEL_BITS-1:0]        pal_idx,
    input  logic [3*VGA_COLOR_DEPTH-1:0] pal_rgb,
    input  logic                         swap_req,
    output logic                         swap_pending,
    output logic                         front_buf,
    output logic [VGA_COLOR_DEPTH-1:0]   vga_r,
    output logic [VGA_COLOR_DEPTH-1:0]   vga_g,
    output logic [VGA_COLOR_DEPTH-1:0]   vga_b,
    output logic                         hsync,
    output logic                         vsync,
    output logic                         vga_visible
);

    localparam int          FB_SIZE = FB_WIDTH * FB_HEIGHT;
    localparam int          AW      = 15;
    localparam int          CW      = 3 * VGA_COLOR_DEPTH;
    localparam int unsigned PAL_N   = 1 << PIXEL_BITS;

    typedef enum logic {
        S_IDLE,
        S_PENDING
    } swap_state_e;

    swap_state_e            state_q;
    logic                   front_q;
    logic                   pend_q;
    logic                   ready_q;
    logic                   vs_prev_q;

    logic [PIXEL_BITS-1:0]  fb0_mem [FB_SIZE];
    logic [PIXEL_BITS-1:0]  fb1_mem [FB_SIZE];
    logic [CW-1:0]          pal_q   [PAL_N];

    logic [PIXEL_BITS-1:0]  idx_q;
    logic                   vis1_q, hs1_q, vs1_q;
    logic                   vis2_q, hs2_q, vs2_q;
    logic [CW-1:0]          rgb_q;

    logic [9:0]             fb_x, fb_y;
    int                     rd_lin;
    logic [AW-1:0]          rd_addr;
    logic                   wr_fire;
    logic                   vsync_start;

    assign fb_x = pixel_x >> SCALE_SHIFT;
    assign fb_y = pixel_y >> SCALE_SHIFT;

    // Out-of-range coordinates read address 0 so the RAM index stays in bounds.
    always_comb begin
        rd_lin  = int'(fb_y) * FB_WIDTH + int'(fb_x);
        rd_addr = '0;
        if (visible_in && rd_lin < FB_SIZE) begin
            rd_addr = AW'(rd_lin);
        end
    end

    assign wr_fire     = wr_valid && ready_q && (int'(wr_addr) < FB_SIZE);
    assign vsync_start = !vsync_in && vs_prev_q;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            if (front_q) begin
                fb0_mem[wr_addr] <= wr_data;
            end else begin
                fb1_mem[wr_addr] <= wr_data;
            end
        end
        idx_q <= front_q ? fb1_mem[rd_addr] : fb0_mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PAL_N; i++) begin
                pal_q[i] <= {3{VGA_COLOR_DEPTH'(i)}};
            end
        end else if (pal_we) begin
            pal_q[pal_idx] <= pal_rgb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vis1_q <= 1'b0;
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            vis2_q <= 1'b0;
            hs2_q  <= 1'b1;
            vs2_q  <= 1'b1;
            rgb_q  <= '0;
        end else begin
            vis1_q <= visible_in;
            hs1_q  <= hsync_in;
            vs1_q  <= vsync_in;
            vis2_q <= vis1_q;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
            rgb_q  <= vis1_q ? pal_q[idx_q] : '0;
        end
    end

    // A request arriving on the vsync-start cycle swaps immediately without pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            front_q   <= 1'b0;
            pend_q    <= 1'b0;
            ready_q   <= 1'b0;
            vs_prev_q <= 1'b1;
        end else begin
            vs_prev_q <= vsync_in;
            if (vsync_start && (state_q == S_PENDING || swap_req)) begin
                state_q <= S_IDLE;
                front_q <= ~front_q;
                pend_q  <= 1'b0;
                ready_q <= 1'b1;
            end else if (swap_req || state_q == S_PENDING) begin
                state_q <= S_PENDING;
                pend_q  <= 1'b1;
                ready_q <= 1'b0;
            end else begin
                state_q <= S_IDLE;
                pend_q  <= 1'b0;
                ready_q <= 1'b1;
            end
        end
    end

    assign wr_ready     = ready_q;
    assign swap_pending = pend_q;
    assign front_buf    = front_q;
    assign vga_r        = rgb_q[CW-1 -: VGA_COLOR_DEPTH];
    assign vga_g        = rgb_q[2*VGA_COLOR_DEPTH-1 -: VGA_COLOR_DEPTH];
    assign vga_b        = rgb_q[VGA_COLOR_DEPTH-1:0];
    assign hsync        = hs2_q;
    assign vsync        = vs2_q;
    assign vga_visible  = vis2_q;

endmodule
